// File: rtl/riscv_defines.sv
// Shared definitions for the core pipeline.
// Holds the memory access size encoding, the funct3 codes for loads and stores,
// and small helpers that decode size, alignment and byte enables from funct3
// and the low two address bits.
package riscv_defines;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    // Access size from funct3; the unused codes 011, 110 and 111 fall back to word.
    function automatic mem_size_e funct3_size(input logic [2:0] funct3);
        mem_size_e size;
        case (funct3[1:0])
            2'b00:   size = MEM_B;
            2'b01:   size = MEM_H;
            default: size = MEM_W;
        endcase
        return size;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned address.
    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lsb);
        logic mis;
        case (size)
            MEM_B:   mis = 1'b0;
            MEM_H:   mis = addr_lsb[0];
            default: mis = (addr_lsb != 2'b00);
        endcase
        return mis;
    endfunction

    // Store byte enables for the selected lane(s).
    function automatic logic [3:0] store_be(input mem_size_e size, input logic [1:0] addr_lsb);
        logic [3:0] be;
        case (size)
            MEM_B:   be = 4'b0001 << addr_lsb;
            MEM_H:   be = addr_lsb[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load data aligner.
// Picks the byte or halfword addressed by addr_lsb out of the 32-bit bus word,
// right-justifies it and sign- or zero-extends according to funct3[2].
// Ports: rdata (bus word), addr_lsb (address bits [1:0]), funct3 (size/sign),
//        data (aligned 32-bit result).
module load_aligner
    import riscv_defines::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lsb,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    mem_size_e   size_s;

    // Lane selection and extension.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        data   = rdata;
        size_s = funct3_size(funct3);
        case (addr_lsb)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        half_s = addr_lsb[1] ? rdata[31:16] : rdata[15:0];
        case (size_s)
            MEM_B:   data = funct3[2] ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
            MEM_H:   data = funct3[2] ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage.
// Issues loads/stores on the req/gnt/rvalid data bus (one outstanding access),
// aligns load data and registers the writeback bundle for the WB stage.
// Ports: ex_* / store_data_i / reg_* / load_i / store_i / mem_funct3_i from
//        execute; mem_stall_o back to the front end; data_* bus to memory;
//        wb_* and misaligned_o registered towards writeback.
module mem_stage
    import riscv_defines::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    input  logic [WORD_WIDTH-1:0] ex_data_i,
    input  logic [WORD_WIDTH-1:0] store_data_i,
    input  logic [ADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic                  load_i,
    input  logic                  store_i,
    input  logic [2:0]            mem_funct3_i,
    output logic                  mem_stall_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic [WORD_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [WORD_WIDTH-1:0] data_wdata_o,
    input  logic [WORD_WIDTH-1:0] data_rdata_i,
    output logic                  wb_valid_o,
    output logic [WORD_WIDTH-1:0] wb_data_o,
    output logic [ADDR_WIDTH-1:0] wb_waddr_o,
    output logic                  wb_we_o,
    output logic                  misaligned_o
);

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        WAIT_GNT    = 2'b01,
        WAIT_RVALID = 2'b10
    } state_e;

    state_e                state_r, state_next_s;
    mem_size_e             size_s;
    logic [1:0]            addr_lsb_s;
    logic                  mem_op_s, misaligned_s, we_ok_s;
    logic                  req_s, stall_s;
    logic [WORD_WIDTH-1:0] load_data_s;
    logic                  wb_valid_r, wb_we_r, mis_r;
    logic [WORD_WIDTH-1:0] wb_data_r;
    logic [ADDR_WIDTH-1:0] wb_waddr_r;
    logic                  wb_valid_s, wb_we_s, mis_s;
    logic [WORD_WIDTH-1:0] wb_data_s;
    logic [ADDR_WIDTH-1:0] wb_waddr_s;

    load_aligner u_load_aligner (
        .rdata    (data_rdata_i),
        .addr_lsb (addr_lsb_s),
        .funct3   (mem_funct3_i),
        .data     (load_data_s)
    );

    // Access decode; upstream is held during a transaction so these stay valid.
    always_comb begin
        addr_lsb_s   = ex_data_i[1:0];
        size_s       = funct3_size(mem_funct3_i);
        mem_op_s     = ex_valid_i & (load_i | store_i);
        misaligned_s = is_misaligned(size_s, addr_lsb_s);
        we_ok_s      = reg_we_i & (reg_waddr_i != {ADDR_WIDTH{1'b0}});
        data_addr_o  = {ex_data_i[WORD_WIDTH-1:2], 2'b00};
        data_we_o    = store_i;
        data_be_o    = store_i ? store_be(size_s, addr_lsb_s) : 4'b1111;
        case (size_s)
            MEM_B:   data_wdata_o = {4{store_data_i[7:0]}};
            MEM_H:   data_wdata_o = {2{store_data_i[15:0]}};
            default: data_wdata_o = store_data_i;
        endcase
    end

    // Next-state, bus handshake, stall and next writeback bundle.
    always_comb begin
        state_next_s = state_r;
        req_s        = 1'b0;
        stall_s      = 1'b0;
        wb_valid_s   = 1'b0;
        wb_we_s      = 1'b0;
        mis_s        = 1'b0;
        wb_data_s    = wb_data_r;
        wb_waddr_s   = wb_waddr_r;
        case (state_r)
            IDLE: begin
                if (ex_valid_i) begin
                    if (mem_op_s && misaligned_s) begin
                        // Dropped access: retire as a non-writing instruction.
                        wb_valid_s = 1'b1;
                        wb_data_s  = ex_data_i;
                        wb_waddr_s = reg_waddr_i;
                        mis_s      = 1'b1;
                    end else if (mem_op_s) begin
                        req_s        = 1'b1;
                        stall_s      = 1'b1;
                        // rvalid in this same cycle is illegal and simply ignored.
                        state_next_s = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                    end else begin
                        wb_valid_s = 1'b1;
                        wb_we_s    = we_ok_s;
                        wb_data_s  = ex_data_i;
                        wb_waddr_s = reg_waddr_i;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT_GNT: begin
                req_s   = 1'b1;
                stall_s = 1'b1;
                if (data_gnt_i) begin
                    state_next_s = WAIT_RVALID;
                end else begin
                    state_next_s = WAIT_GNT;
                end
            end
            WAIT_RVALID: begin
                if (data_rvalid_i) begin
                    state_next_s = IDLE;
                    wb_valid_s   = 1'b1;
                    wb_waddr_s   = reg_waddr_i;
                    // Stores retire with the address as data and no register write.
                    wb_we_s      = load_i & we_ok_s;
                    wb_data_s    = load_i ? load_data_s : ex_data_i;
                end else begin
                    stall_s      = 1'b1;
                    state_next_s = WAIT_RVALID;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Writeback bundle register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_r <= 1'b0;
            wb_we_r    <= 1'b0;
            mis_r      <= 1'b0;
            wb_data_r  <= {WORD_WIDTH{1'b0}};
            wb_waddr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            wb_valid_r <= wb_valid_s;
            wb_we_r    <= wb_we_s;
            mis_r      <= mis_s;
            wb_data_r  <= wb_data_s;
            wb_waddr_r <= wb_waddr_s;
        end
    end

    // Request is forced low while reset is asserted, whatever the inputs show.
    assign data_req_o   = req_s & rst_n;
    assign mem_stall_o  = stall_s;
    assign wb_valid_o   = wb_valid_r;
    assign wb_we_o      = wb_we_r;
    assign wb_data_o    = wb_data_r;
    assign wb_waddr_o   = wb_waddr_r;
    assign misaligned_o = mis_r;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid_i, reg_we_i, load_i, store_i;
    logic [31:0] ex_data_i, store_data_i, data_rdata_i;
    logic [4:0]  reg_waddr_i;
    logic [2:0]  mem_funct3_i;
    logic        data_gnt_i, data_rvalid_i;
    logic        mem_stall_o, data_req_o, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o, wb_data_o;
    logic [3:0]  data_be_o;
    logic        wb_valid_o, wb_we_o, misaligned_o;
    logic [4:0]  wb_waddr_o;

    int n_checks = 0;
    int n_pass   = 0;

    mem_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid_i    (ex_valid_i),
        .ex_data_i     (ex_data_i),
        .store_data_i  (store_data_i),
        .reg_waddr_i   (reg_waddr_i),
        .reg_we_i      (reg_we_i),
        .load_i        (load_i),
        .store_i       (store_i),
        .mem_funct3_i  (mem_funct3_i),
        .mem_stall_o   (mem_stall_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rdata_i  (data_rdata_i),
        .wb_valid_o    (wb_valid_o),
        .wb_data_o     (wb_data_o),
        .wb_waddr_o    (wb_waddr_o),
        .wb_we_o       (wb_we_o),
        .misaligned_o  (misaligned_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [4:0]  waddr;
        logic        we;
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb_data;
        logic        exp_wb_we;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] waddr, input logic we);
        ex_valid_i   = v;
        load_i       = ld;
        store_i      = st;
        mem_funct3_i = f3;
        ex_data_i    = addr;
        store_data_i = sdata;
        reg_waddr_i  = waddr;
        reg_we_i     = we;
    endtask

    // One instruction with gnt in the issue cycle and rvalid in the next.
    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        drive(1'b1, v.ld, v.st, v.f3, v.addr, v.sdata, v.waddr, v.we);
        data_gnt_i    = 1'b1;
        data_rvalid_i = 1'b0;
        @(negedge clk);
        chk({tag, ".req"}, {31'd0, data_req_o}, {31'd0, v.exp_req});
        chk({tag, ".stall"}, {31'd0, mem_stall_o}, {31'd0, v.exp_req});
        if (v.exp_req) begin
            chk({tag, ".addr"}, data_addr_o, {v.addr[31:2], 2'b00});
            chk({tag, ".we"}, {31'd0, data_we_o}, {31'd0, v.st});
            chk({tag, ".be"}, {28'd0, data_be_o}, {28'd0, v.exp_be});
            if (v.st) chk({tag, ".wdata"}, data_wdata_o, v.exp_wdata);
            tick();
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b1;
            data_rdata_i  = v.rdata;
            @(negedge clk);
            chk({tag, ".req_wait"}, {31'd0, data_req_o}, 32'd0);
            chk({tag, ".stall_rvalid"}, {31'd0, mem_stall_o}, 32'd0);
        end
        tick();
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        chk({tag, ".wb_valid"}, {31'd0, wb_valid_o}, 32'd1);
        chk({tag, ".wb_data"}, wb_data_o, v.exp_wb_data);
        chk({tag, ".wb_waddr"}, {27'd0, wb_waddr_o}, {27'd0, v.waddr});
        chk({tag, ".wb_we"}, {31'd0, wb_we_o}, {31'd0, v.exp_wb_we});
        chk({tag, ".mis"}, {31'd0, misaligned_o}, {31'd0, v.exp_mis});
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    initial begin
        //          ld    st    f3      addr          sdata         rdata         wa    we    req   be       wdata         wb_data       wbwe  mis
        vecs[0]  = '{1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0,        32'h0,        5'd5, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0000_1234, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'h0,        32'h0,        5'd0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0,        32'h1234_5678, 5'd4, 1'b1, 1'b1, 4'b1111, 32'h0,        32'h0000_0056, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'h0000_007F, 5'd6, 1'b1, 1'b1, 4'b1111, 32'h0,        32'h0000_007F, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_0000, 5'd8, 1'b1, 1'b1, 4'b1111, 32'h0,        32'hFFFF_8001, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0012, 32'h0,        32'hF00D_0000, 5'd0, 1'b1, 1'b1, 4'b1111, 32'h0,        32'h0000_F00D, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hCAFE_BABE, 5'd7, 1'b1, 1'b1, 4'b1111, 32'h0,        32'hCAFE_BABE, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0104, 32'h0,        32'h89AB_CDEF, 5'd9, 1'b1, 1'b1, 4'b1111, 32'h0,        32'h89AB_CDEF, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'h0,        5'd1, 1'b1, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0201, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0,        5'd1, 1'b1, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0000_0202, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h1234_5677, 32'h0,        5'd1, 1'b0, 1'b1, 4'b1000, 32'h7777_7777, 32'h0000_0203, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h1122_3344, 32'h0,        5'd1, 1'b0, 1'b1, 4'b1111, 32'h1122_3344, 32'h0000_0300, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 3'b001, 32'h0000_0200, 32'hFFFF_0102, 32'h0,        5'd1, 1'b0, 1'b1, 4'b0011, 32'h0102_0102, 32'h0000_0200, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        5'd3, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0000_0006, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        5'd3, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0000_0101, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 3'b010, 32'h0000_0302, 32'h0,        32'h0,        5'd2, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_0302, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h0,        32'h0,        5'd2, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_0203, 1'b0, 1'b1};

        // Reset with a load presented: no request may escape, wb_* cleared.
        rst_n         = 1'b0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'd0;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 5'd1, 1'b1);
        tick();
        @(negedge clk);
        chk("rst.req", {31'd0, data_req_o}, 32'd0);
        chk("rst.wb_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("rst.wb_data", wb_data_o, 32'd0);
        chk("rst.wb_waddr", {27'd0, wb_waddr_o}, 32'd0);
        chk("rst.wb_we", {31'd0, wb_we_o}, 32'd0);
        chk("rst.mis", {31'd0, misaligned_o}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            run_vec(i, vecs[i]);
        end

        // Misaligned pulse lasts one cycle only.
        tick();
        chk("mis_pulse.after", {31'd0, misaligned_o}, 32'd0);
        chk("mis_pulse.wb_valid", {31'd0, wb_valid_o}, 32'd0);

        // LB at 0x103: gnt after two wait cycles, rvalid two cycles later.
        begin
            logic [4:0] stall_pat;
            logic [4:0] req_pat;
            int         stalls;
            stall_pat = 5'b01111;
            req_pat   = 5'b00111;
            stalls    = 0;
            drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 5'd3, 1'b1);
            for (int k = 0; k < 5; k++) begin
                data_gnt_i    = (k == 2);
                data_rvalid_i = (k == 4);
                data_rdata_i  = (k == 4) ? 32'h8000_0000 : 32'd0;
                @(negedge clk);
                chk($sformatf("lb_wait.stall%0d", k), {31'd0, mem_stall_o}, {31'd0, stall_pat[k]});
                chk($sformatf("lb_wait.req%0d", k), {31'd0, data_req_o}, {31'd0, req_pat[k]});
                if (k == 0) chk("lb_wait.be", {28'd0, data_be_o}, 32'h0000_000F);
                if (mem_stall_o) stalls++;
                tick();
            end
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
            chk("lb_wait.stall_count", stalls, 32'd4);
            chk("lb_wait.wb_valid", {31'd0, wb_valid_o}, 32'd1);
            chk("lb_wait.wb_data", wb_data_o, 32'hFFFF_FF80);
            chk("lb_wait.wb_we", {31'd0, wb_we_o}, 32'd1);
        end

        // Invalid cycle with stray gnt/rvalid: no request, wb_data/waddr hold.
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_5554, 32'd0, 5'd9, 1'b1);
        data_gnt_i    = 1'b1;
        data_rvalid_i = 1'b1;
        @(negedge clk);
        chk("idle.req", {31'd0, data_req_o}, 32'd0);
        chk("idle.stall", {31'd0, mem_stall_o}, 32'd0);
        tick();
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        chk("idle.wb_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("idle.wb_we", {31'd0, wb_we_o}, 32'd0);
        chk("idle.wb_data_hold", wb_data_o, 32'hFFFF_FF80);
        chk("idle.wb_waddr_hold", {27'd0, wb_waddr_o}, 32'd3);

        // gnt and rvalid together at issue: rvalid ignored, completion needs a later rvalid.
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0, 5'd10, 1'b1);
        data_gnt_i    = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h1111_1111;
        tick();
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        chk("both.wb_valid_early", {31'd0, wb_valid_o}, 32'd0);
        @(negedge clk);
        chk("both.stall_wait", {31'd0, mem_stall_o}, 32'd1);
        tick();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h0BAD_F00D;
        @(negedge clk);
        chk("both.stall_done", {31'd0, mem_stall_o}, 32'd0);
        tick();
        data_rvalid_i = 1'b0;
        chk("both.wb_valid", {31'd0, wb_valid_o}, 32'd1);
        chk("both.wb_data", wb_data_o, 32'h0BAD_F00D);

        // Reset in WAIT_RVALID, late rvalid after release is ignored.
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 5'd2, 1'b1);
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst.req", {31'd0, data_req_o}, 32'd0);
        chk("midrst.wb_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("midrst.wb_data", wb_data_o, 32'd0);
        chk("midrst.wb_waddr", {27'd0, wb_waddr_o}, 32'd0);
        chk("midrst.wb_we", {31'd0, wb_we_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h0000_FFFF;
        @(negedge clk);
        chk("late_rvalid.req", {31'd0, data_req_o}, 32'd0);
        chk("late_rvalid.stall", {31'd0, mem_stall_o}, 32'd0);
        tick();
        data_rvalid_i = 1'b0;
        chk("late_rvalid.wb_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("late_rvalid.wb_we", {31'd0, wb_we_o}, 32'd0);
        chk("late_rvalid.wb_data", wb_data_o, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
